// File: rtl/nn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_ctrl_pkg
// Purpose  : Shared types and bit indices for the NN accelerator sequencer.
//            - state_t: FSM state, encoded as the status_reg state code.
//            - CTRL_*: bit positions in ctrl_reg.
//            - ERR_*: bit positions of the sticky error flags.
//            - strobe_t / state_strobes(): the datapath strobe set for each
//              state.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADW = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_BIAS  = 3'd4,
    ST_ACT   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_CLR_ERR = 2;
  localparam int CTRL_CLR_WT  = 3;

  localparam int ERR_WT_OVF     = 0;
  localparam int ERR_IN_OVF     = 1;
  localparam int ERR_NO_WTS     = 2;
  localparam int ERR_NO_INPUT   = 3;
  localparam int ERR_START_BUSY = 4;
  localparam int ERR_PUSH_BUSY  = 5;
  localparam int ERR_W          = 6;

  typedef struct packed {
    logic wt_load;
    logic in_pop;
    logic array_en;
    logic bias_en;
    logic act_en;
    logic out_valid;
  } strobe_t;

  // Strobes asserted for the whole time the FSM sits in state s.
  function automatic strobe_t state_strobes(input state_t s);
    strobe_t st;
    st = '0;
    case (s)
      ST_LOADW: st.wt_load = 1'b1;
      ST_FEED: begin
        st.in_pop   = 1'b1;
        st.array_en = 1'b1;
      end
      ST_DRAIN: st.array_en  = 1'b1;
      ST_BIAS:  st.bias_en   = 1'b1;
      ST_ACT:   st.act_en    = 1'b1;
      ST_DONE:  st.out_valid = 1'b1;
      default:  st = '0;
    endcase
    return st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nn_load_cnt.sv
`default_nettype none
// ============================================================================
// Module   : nn_load_cnt
// Purpose  : Saturating up/down occupancy counter, range 0..MAX.
//            An increment while full is dropped and reported on ovf.
//            A decrement while empty is ignored. clr has priority.
// Ports    : clk    in      clock
//            n_rst  in      async active-low reset
//            inc    in      count up by one
//            dec    in      count down by one
//            clr    in      force count to zero next cycle
//            cnt    out [W] current count
//            full   out     cnt == MAX
//            empty  out     cnt == 0
//            ovf    out     inc presented while full (combinational pulse)
// Revision : 1.0 - initial release
// ============================================================================
module nn_load_cnt #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         full,
  output logic         empty,
  output logic         ovf
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic inc_ok;
  logic dec_ok;

  assign full   = (cnt == MAX_V);
  assign empty  = (cnt == '0);
  assign ovf    = inc & full;
  assign inc_ok = inc & ~full;
  assign dec_ok = dec & ~empty;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc_ok && !dec_ok) begin
      cnt <= cnt + 1'b1;
    end else if (dec_ok && !inc_ok) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nn_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nn_sched_ctrl
// Purpose  : Sequencer for the NN accelerator datapath behind ahb_sub.
//            Counts weight/input words pushed from the bus. On a start edge
//            it runs LOADW -> FEED -> DRAIN -> BIAS -> ACT -> DONE and drives
//            the array and FIFO strobes. It also reports status and sticky
//            errors for bus readback.
// Ports    : clk         in       system clock
//            n_rst       in       async active-low reset
//            ctrl_reg    in  [8]  [0] start [1] abort [2] clr_err [3] clr_wts
//            wr_en_push  in       one 64b word pushed this cycle
//            is_weight   in       1 = weight FIFO push, 0 = input FIFO push
//            wt_load     out      weight FIFO -> array load strobe
//            in_pop      out      input FIFO pop / array feed strobe
//            array_en    out      MAC array enable
//            bias_en     out      add bias this cycle
//            act_en      out      apply activation this cycle
//            out_valid   out      output register capture strobe
//            status_reg  out [8]  [0] busy [1] done [2] wts_loaded
//                                 [3] err_any [4] 0 [7:5] state code
//            err_reg     out [16] sticky error flags in [5:0]
// Revision : 1.0 - initial release
// ============================================================================
module nn_sched_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_WEIGHTS = 8,
  parameter int INPUT_DEPTH = 8,
  parameter int ARRAY_LAT   = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  ctrl_reg,
  input  logic        wr_en_push,
  input  logic        is_weight,
  output logic        wt_load,
  output logic        in_pop,
  output logic        array_en,
  output logic        bias_en,
  output logic        act_en,
  output logic        out_valid,
  output logic [7:0]  status_reg,
  output logic [15:0] err_reg
);

  localparam int WT_W   = $clog2(NUM_WEIGHTS + 1);
  localparam int IN_W   = $clog2(INPUT_DEPTH + 1);
  localparam int PH_MAX = (NUM_WEIGHTS > ARRAY_LAT) ? NUM_WEIGHTS : ARRAY_LAT;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  state_t            state;
  state_t            state_nx;
  strobe_t           strb;
  logic [PH_W-1:0]   phase;
  logic              start_q;
  logic              done;
  logic [ERR_W-1:0]  err;
  logic [ERR_W-1:0]  err_set;

  logic [WT_W-1:0]   wt_cnt;
  logic [IN_W-1:0]   in_cnt;
  logic              wts_loaded;
  logic              in_empty;
  logic              wt_ovf;
  logic              in_ovf;
  logic              wt_empty_unused;
  logic              in_full_unused;
  logic              ctrl_unused;

  logic is_idle;
  logic start_edge;
  logic abort;
  logic start_ok;

  assign ctrl_unused = ^ctrl_reg[7:4];

  assign is_idle    = (state == ST_IDLE);
  assign start_edge = ctrl_reg[CTRL_START] & ~start_q;
  assign abort      = ctrl_reg[CTRL_ABORT] & ~is_idle;
  assign start_ok   = is_idle & start_edge & wts_loaded & ~in_empty;

  // Pushes only count in IDLE; the counters never see a push while busy.
  nn_load_cnt #(
    .MAX (NUM_WEIGHTS),
    .W   (WT_W)
  ) u_wt_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (wr_en_push & is_weight & is_idle),
    .dec   (1'b0),
    .clr   (ctrl_reg[CTRL_CLR_WT] & is_idle),
    .cnt   (wt_cnt),
    .full  (wts_loaded),
    .empty (wt_empty_unused),
    .ovf   (wt_ovf)
  );

  // Drained one word per FEED cycle; an abort discards whatever is left.
  nn_load_cnt #(
    .MAX (INPUT_DEPTH),
    .W   (IN_W)
  ) u_in_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (wr_en_push & ~is_weight & is_idle),
    .dec   (state == ST_FEED),
    .clr   (abort),
    .cnt   (in_cnt),
    .full  (in_full_unused),
    .empty (in_empty),
    .ovf   (in_ovf)
  );

  // Next-state decode. Abort outranks every other transition.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_ok) state_nx = ST_LOADW;
        ST_LOADW: if (phase == PH_W'(NUM_WEIGHTS - 1)) state_nx = ST_FEED;
        // The word popped this cycle is the last one when one remains.
        ST_FEED:  if (in_cnt <= IN_W'(1)) state_nx = ST_DRAIN;
        ST_DRAIN: if (phase == PH_W'(ARRAY_LAT - 1)) state_nx = ST_BIAS;
        ST_BIAS:  state_nx = ST_ACT;
        ST_ACT:   state_nx = ST_DONE;
        ST_DONE:  state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    err_set                 = '0;
    err_set[ERR_WT_OVF]     = wt_ovf;
    err_set[ERR_IN_OVF]     = in_ovf;
    err_set[ERR_NO_WTS]     = is_idle & start_edge & ~wts_loaded;
    err_set[ERR_NO_INPUT]   = is_idle & start_edge & wts_loaded & in_empty;
    err_set[ERR_START_BUSY] = ~is_idle & start_edge;
    err_set[ERR_PUSH_BUSY]  = ~is_idle & wr_en_push;
  end

  // Strobes are registered from the next state so that they line up exactly
  // with the state they belong to without any combinational input path.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= ST_IDLE;
      strb    <= '0;
      phase   <= '0;
      start_q <= 1'b0;
      done    <= 1'b0;
      err     <= '0;
    end else begin
      state   <= state_nx;
      strb    <= state_strobes(state_nx);
      start_q <= ctrl_reg[CTRL_START];

      // Phase counts cycles spent in the multi-cycle timed states.
      if ((state_nx != state) ||
          !((state == ST_LOADW) || (state == ST_DRAIN))) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end

      if (start_ok) begin
        done <= 1'b0;
      end else if ((state == ST_DONE) && !abort) begin
        done <= 1'b1;
      end

      // A clear and a new error in the same cycle leave the new bit set.
      err <= (ctrl_reg[CTRL_CLR_ERR] ? '0 : err) | err_set;
    end
  end

  assign wt_load   = strb.wt_load;
  assign in_pop    = strb.in_pop;
  assign array_en  = strb.array_en;
  assign bias_en   = strb.bias_en;
  assign act_en    = strb.act_en;
  assign out_valid = strb.out_valid;

  assign status_reg = {state, 1'b0, |err, wts_loaded, done, ~is_idle};
  assign err_reg    = {{(16 - ERR_W){1'b0}}, err};

endmodule
`default_nettype wire
